stoch_bitstream_decoder: RTL
============================

Name: stoch_bitstream_decoder

Overview:
- Stochastic-to-binary converter; the decode end of the design's LFSR-based stochastic bitstream path.
- Counts ones in a serial bitstream over a fixed window of 2^W-1 valid bits and emits the count as a W-bit unsigned value, i.e. the estimated probability scaled to 2^W-1.
- Sits after the stochastic multiply/add gates; its result drives the dedicated output pins or a downstream register.
- Start / valid-ready handshake so repeated windows can be decoded back-to-back.

Parameters:
- W, 8, result width; window length N = 2^W-1 valid bits, so the count never overflows W bits.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- start_i  input  1  begin a new window; honoured only in IDLE, or in HOLD when the result is accepted the same cycle.
- bit_i  input  1  stochastic bitstream sample.
- bit_valid_i  input  1  bit_i is valid this cycle; invalid cycles are skipped, not counted.
- busy_o  output  1  high in ACCUM.
- result_o  output  W  ones count for the completed window; stable while result_valid_o is high.
- result_valid_o  output  1  result available; level signal held until accepted.
- result_ready_i  input  1  consumer accepts result when result_valid_o and result_ready_i are both high.

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, ones count=0, valid-bit index=0, result_o=0, result_valid_o=0, busy_o=0. Reset wins over every other input, including mid-window; the partial count is discarded.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - start_i=1 -> ACCUM; clear count and index.
  - bit_i is not sampled on the start cycle.
  - start_i=0 -> stay in IDLE.
- ACCUM, each cycle with bit_valid_i=1:
  - count += bit_i; index += 1.
  - On the valid bit where index reaches N-1 (the Nth valid bit), latch result_o = count + bit_i and go to HOLD.
  - result_valid_o rises the next cycle.
  - bit_valid_i=0 holds count and index.
  - start_i is ignored in ACCUM (no restart).
- Latency: with bit_valid_i held high, result_valid_o is asserted N+1 cycles after the start cycle. For W=8 that is 256 cycles.
- HOLD:
  - result_valid_o=1; result_o frozen.
  - result_ready_i=1 and start_i=0 -> IDLE; result_valid_o drops next cycle; result_o keeps its last value.
  - result_ready_i=1 and start_i=1 -> ACCUM directly (back-to-back window, no IDLE bubble); count and index are cleared.
  - result_ready_i=0 -> stay in HOLD; bits are ignored and start_i is ignored.
- Arithmetic: count is W bits unsigned. Its maximum is N = 2^W-1, so there is no wrap or saturation logic. The index is W bits and wraps only via the explicit clear.
- busy_o = (state==ACCUM), registered.
- No combinational path from any input to any output.

Decomposition:
- Package stoch_pkg holds:
  - state enum {ST_IDLE, ST_ACCUM, ST_HOLD};
  - default W localparam;
  - a window-length function N(W) = 2^W-1.
- The shared LFSR seed and taps constants (31-bit, taps 30/27, seed 1) also go there, for reuse by the bench.
- One natural sub-module: stoch_ones_counter. It holds the W-bit count and index with clear / enable / bit inputs and a terminal flag (index==N-1 && enable). The FSM and handshake stay in the top.

Test Plan:
- bit_i=1 and bit_valid_i=1 constantly, W=8, start pulse at cycle 0 -> result_valid_o at cycle 256, result_o=255; busy_o high for cycles 1..255.
- bit_i=0 constantly -> result_o=0. Alternating 1,0,… starting with 1 -> result_o=128.
- bit_i=1, with bit_valid_i low every other cycle -> result_o=255, result_valid_o at cycle 511; start_i pulses mid-window are ignored (no restart, same result).
- Drive bit_i from the 31-bit LFSR MSB (seed 1, feedback bit30^bit27):
  - result_o must equal the reference model's ones count over those 255 bits;
  - result_ready_i held low for 10 cycles -> result_o/result_valid_o stable throughout;
  - then assert ready with start_i=1 -> next window begins with no IDLE cycle and busy_o high the next cycle.
- rst_n low for one cycle at index 100 of an all-ones window -> state IDLE, result_o=0, result_valid_o=0. A new start then gives 255, proving no stale count remains.

Source files
------------

// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic bitstream path: decoder FSM
// states, default result width, window length and the LFSR generator constants.
package stoch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int unsigned W_DEFAULT = 8;

    // 31-bit Fibonacci LFSR used to generate stochastic streams; MSB is the output bit.
    localparam int unsigned LFSR_W      = 31;
    localparam logic [30:0] LFSR_SEED   = 31'd1;
    localparam int unsigned LFSR_TAP_HI = 30;
    localparam int unsigned LFSR_TAP_LO = 27;

    // Window length in valid bits; chosen so a full-ones window still fits in w bits.
    function automatic int unsigned win_len(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/stoch_ones_counter.sv
// Ones counter for one decode window: W-bit count and W-bit valid-bit index,
// with synchronous clear, per-bit enable and a flag on the last bit of the window.
module stoch_ones_counter
    import stoch_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] count_next_o,
    output logic         term_o
);

    localparam logic [W-1:0] LAST_IDX = W'(win_len(W) - 32'd1);

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] index_q, index_d;

    always_comb begin
        count_d = count_q;
        index_d = index_q;
        if (clr_i) begin
            count_d = '0;
            index_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(bit_i);
            index_d = index_q + W'(1);
        end
    end

    // Count including the current bit, so the final window value is ready on the terminal bit.
    assign count_next_o = count_q + W'(bit_i);
    assign term_o       = en_i && (index_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            index_q <= '0;
        end else begin
            count_q <= count_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/stoch_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^W-1 valid bits and presents
// the count through a start / valid-ready handshake. All outputs are registered.
module stoch_bitstream_decoder
    import stoch_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         bit_i,
    input  logic         bit_valid_i,
    output logic         busy_o,
    output logic [W-1:0] result_o,
    output logic         result_valid_o,
    input  logic         result_ready_i
);

    state_t       state_q, state_d;
    logic [W-1:0] result_q, result_d;
    logic         result_valid_q, result_valid_d;
    logic         busy_q, busy_d;

    logic         cnt_clr;
    logic         cnt_en;
    logic [W-1:0] cnt_next;
    logic         cnt_term;

    stoch_ones_counter #(
        .W (W)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (cnt_clr),
        .en_i         (cnt_en),
        .bit_i        (bit_i),
        .count_next_o (cnt_next),
        .term_o       (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ACCUM;
                    cnt_clr = 1'b1;
                end
            end
            ST_ACCUM: begin
                cnt_en = bit_valid_i;
                if (cnt_term) begin
                    state_d  = ST_HOLD;
                    result_d = cnt_next;
                end
            end
            ST_HOLD: begin
                // Accept plus start restarts immediately, skipping the IDLE bubble.
                if (result_ready_i) begin
                    if (start_i) begin
                        state_d = ST_ACCUM;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d         = (state_d == ST_ACCUM);
        result_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;

endmodule
